// File: rtl/cb_segment_ctrl.sv
// cb_segment_ctrl: splits one transport block into one or two code blocks.
// Each descriptor gives the small/large block counts and the filler length.
// The controller emits filler bytes, passes input data through, and inserts
// zero-valued CRC placeholders. All output goes through a one-byte register.
// Phase and block boundaries advance on output handshakes, so the byte
// counter always reflects bytes actually accepted downstream.
module cb_segment_ctrl #(
    parameter int K_LARGE   = 768,
    parameter int K_SMALL   = 132,
    parameter int CRC_BYTES = 3
) (
    input  logic        clk,
    input  logic        aclr,
    input  logic        desc_empty,
    output logic        desc_rdreq,
    input  logic [19:0] desc_q,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_sob,
    output logic        out_eob,
    output logic        out_filler,
    output logic        out_crc_slot,
    output logic [1:0]  out_cb_idx,
    output logic        busy,
    output logic        desc_error
);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, FILL, DATA, CRC} state_t;

    localparam logic [9:0] KL   = 10'(K_LARGE);
    localparam logic [9:0] KS   = 10'(K_SMALL);
    localparam logic [9:0] CRCL = 10'(CRC_BYTES);

    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;            // block bytes not yet handshaken
    logic [9:0]  fill_thr_q, fill_thr_d;  // cnt value at which filler ends
    logic [1:0]  cidx_q, cidx_d;
    logic [1:0]  nblk_q, nblk_d;
    logic [1:0]  cm_q, cm_d;
    logic        crc_en_q, crc_en_d;
    logic        err_q, err_d;
    logic        ov_q, ov_d;
    logic [7:0]  od_q, od_d;
    logic        sob_q, sob_d, eob_q, eob_d, fil_q, fil_d, crcs_q, crcs_d;
    logic [1:0]  oidx_q, oidx_d;

    // Descriptor decode (only meaningful while in LOAD)
    logic [1:0]  dq_cp, dq_cm;
    logic [15:0] dq_fill;
    logic [2:0]  dq_c;
    logic        dq_crc, dq_bad;
    logic [9:0]  dq_k0, dq_cap0;

    assign dq_cp   = desc_q[19:18];
    assign dq_cm   = desc_q[17:16];
    assign dq_fill = desc_q[15:0];
    assign dq_c    = {1'b0, dq_cp} + {1'b0, dq_cm};
    assign dq_crc  = (dq_c == 3'd2);
    assign dq_k0   = (dq_cm != 2'd0) ? KS : KL;
    assign dq_cap0 = dq_k0 - (dq_crc ? CRCL : 10'd0);
    assign dq_bad  = (dq_c == 3'd0) || (dq_c > 3'd2) || (dq_fill >= {6'd0, dq_cap0});

    // Phase bookkeeping
    logic [9:0]  end_thr, byte_rem, blk_k, nxt_k;
    logic [1:0]  nidx;
    logic        hs, slot, more, phase_done, blk_done, last_blk, ld;

    assign hs         = ov_q && out_ready;
    assign slot       = !ov_q || out_ready;
    // A pending byte was already loaded, so it does not count as still to load
    assign more       = (cnt_q - end_thr) > {9'd0, ov_q};
    assign phase_done = hs && (cnt_q == end_thr + 10'd1);
    assign byte_rem   = cnt_q - {9'd0, ov_q};
    assign blk_k      = (cidx_q < cm_q) ? KS : KL;
    assign nidx       = cidx_q + 2'd1;
    assign nxt_k      = (nidx < cm_q) ? KS : KL;
    assign last_blk   = (cidx_q == nblk_q - 2'd1);
    assign blk_done   = phase_done && ((state_q == CRC) || (state_q == DATA && !crc_en_q));

    // Remaining-count value at which the current phase is complete
    always_comb begin
        end_thr = 10'd0;
        case (state_q)
            FILL:    end_thr = fill_thr_q;
            DATA:    end_thr = crc_en_q ? CRCL : 10'd0;
            default: end_thr = 10'd0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (!desc_empty) state_d = FETCH;
            FETCH: state_d = LOAD;
            LOAD: begin
                if (dq_bad)               state_d = IDLE;
                else if (dq_fill != 16'd0) state_d = FILL;
                else                      state_d = DATA;
            end
            FILL:  if (phase_done) state_d = DATA;
            DATA: begin
                if (phase_done) begin
                    if (crc_en_q)      state_d = CRC;
                    else if (last_blk) state_d = IDLE;
                    else               state_d = DATA;
                end
            end
            CRC:   if (phase_done) state_d = last_blk ? IDLE : DATA;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: FIFO strobe, input acceptance and output-register load
    always_comb begin
        desc_rdreq = 1'b0;
        in_ready   = 1'b0;
        ld         = 1'b0;
        busy       = (state_q != IDLE);
        case (state_q)
            IDLE:      desc_rdreq = !desc_empty && !aclr;
            FILL, CRC: ld = slot && more;
            DATA: begin
                in_ready = slot && more;
                ld       = slot && more && in_valid;
            end
            default: ;
        endcase
    end

    // Datapath next values: descriptor capture, counters, output register
    always_comb begin
        cnt_d      = cnt_q;
        fill_thr_d = fill_thr_q;
        cidx_d     = cidx_q;
        nblk_d     = nblk_q;
        cm_d       = cm_q;
        crc_en_d   = crc_en_q;
        err_d      = 1'b0;
        ov_d       = ov_q;
        od_d       = od_q;
        sob_d      = sob_q;
        eob_d      = eob_q;
        fil_d      = fil_q;
        crcs_d     = crcs_q;
        oidx_d     = oidx_q;

        if (state_q == LOAD) begin
            cnt_d      = dq_k0;
            fill_thr_d = dq_k0 - dq_fill[9:0];
            cidx_d     = 2'd0;
            nblk_d     = dq_c[1:0];
            cm_d       = dq_cm;
            crc_en_d   = dq_crc;
            err_d      = dq_bad;
        end

        if (hs) begin
            cnt_d = cnt_q - 10'd1;
            if (blk_done && !last_blk) begin
                cidx_d = nidx;
                cnt_d  = nxt_k;
            end
        end

        if (ld) begin
            ov_d   = 1'b1;
            od_d   = (state_q == DATA) ? in_data : 8'h00;
            sob_d  = (byte_rem == blk_k);
            eob_d  = (byte_rem == 10'd1);
            fil_d  = (state_q == FILL);
            crcs_d = (state_q == CRC);
            oidx_d = cidx_q;
        end else if (hs) begin
            ov_d   = 1'b0;
            od_d   = 8'h00;
            sob_d  = 1'b0;
            eob_d  = 1'b0;
            fil_d  = 1'b0;
            crcs_d = 1'b0;
            oidx_d = 2'd0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            cnt_q      <= '0;
            fill_thr_q <= '0;
            cidx_q     <= '0;
            nblk_q     <= '0;
            cm_q       <= '0;
            crc_en_q   <= 1'b0;
            err_q      <= 1'b0;
            ov_q       <= 1'b0;
            od_q       <= '0;
            sob_q      <= 1'b0;
            eob_q      <= 1'b0;
            fil_q      <= 1'b0;
            crcs_q     <= 1'b0;
            oidx_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            fill_thr_q <= fill_thr_d;
            cidx_q     <= cidx_d;
            nblk_q     <= nblk_d;
            cm_q       <= cm_d;
            crc_en_q   <= crc_en_d;
            err_q      <= err_d;
            ov_q       <= ov_d;
            od_q       <= od_d;
            sob_q      <= sob_d;
            eob_q      <= eob_d;
            fil_q      <= fil_d;
            crcs_q     <= crcs_d;
            oidx_q     <= oidx_d;
        end
    end

    assign out_valid    = ov_q;
    assign out_data     = od_q;
    assign out_sob      = sob_q;
    assign out_eob      = eob_q;
    assign out_filler   = fil_q;
    assign out_crc_slot = crcs_q;
    assign out_cb_idx   = oidx_q;
    assign desc_error   = err_q;

endmodule
